// File: rtl/rotate_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one 8-bit rotator, one op in flight.
// `define ROTATE_ARB_RR_EN selects round-robin; otherwise lowest index wins.

module rotate_arbiter_rot (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic       dir,
  output logic [7:0] result
);
  logic [2:0] eff;
  logic [7:0] s4, s2;

  // right rotate by n == left rotate by (8 - n) mod 8
  assign eff    = dir ? (3'd0 - amt) : amt;
  assign s4     = eff[2] ? {data[3:0], data[7:4]} : data;
  assign s2     = eff[1] ? {s4[5:0], s4[7:6]}     : s4;
  assign result = eff[0] ? {s2[6:0], s2[7]}       : s2;
endmodule

module rotate_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [3*N_REQ-1:0] req_amt,
  input  logic [N_REQ-1:0]   req_dir,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [7:0]         rsp_data,
  output logic [IDW-1:0]     rsp_id,
  input  logic               rsp_ready,
  output logic               busy
);
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                  state;
  logic [N_REQ-1:0][7:0]   data_a;
  logic [N_REQ-1:0][2:0]   amt_a;
  logic [IDW-1:0]          win;
  logic                    found;
  logic [7:0]              sel_data;
  logic [2:0]              sel_amt;
  logic                    sel_dir;
  logic [7:0]              rot_res;

  assign data_a = req_data;
  assign amt_a  = req_amt;

`ifdef ROTATE_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   dist, best;

  // winner = valid requester with the smallest circular distance from rr_ptr
  always_comb begin
    win   = '0;
    found = 1'b0;
    dist  = '0;
    best  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) >= rr_ptr) dist = (IDW+1)'(i) - {1'b0, rr_ptr};
      else                   dist = (IDW+1)'(i + N_REQ) - {1'b0, rr_ptr};
      if (req_valid[i] && (!found || dist < best)) begin
        found = 1'b1;
        best  = dist;
        win   = IDW'(i);
      end
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_data = data_a[i];
        sel_amt  = amt_a[i];
        sel_dir  = req_dir[i];
      end
    end
  end

  rotate_arbiter_rot u_rot (
    .data   (sel_data),
    .amt    (sel_amt),
    .dir    (sel_dir),
    .result (rot_res)
  );

  assign req_ready = (state == IDLE && found && !reset) ? (N_REQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
      busy      <= 1'b0;
`ifdef ROTATE_ARB_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          busy      <= 1'b1;
          rsp_data  <= rot_res;
          rsp_id    <= win;
`ifdef ROTATE_ARB_RR_EN
          rr_ptr    <= (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
`endif
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
